// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin arbiter sharing one pearson_hash8 engine between two requesters.
// Define HASH_ARB_TIMEOUT_EN to abort RUN after TIMEOUT_CYCLES cycles with error=1.

module hash_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] msg0,
  input  logic [7:0] msg1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       error,
  output logic       busy,
  output logic [7:0] eng_message,
  output logic       eng_enable,
  output logic       eng_reset_n,
  input  logic       eng_finished,
  input  logic [7:0] eng_hash
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_done0;
  logic       r_done1;
  logic       r_busy;
  logic       r_engEnable;
  logic       r_engResetN;
  logic       r_last;
  logic       r_owner;
  logic [7:0] r_result;
  logic [7:0] r_engMessage;
  logic       w_grant1;
  logic       w_timeout;
  logic       w_finish;

  // On a tie the requester not served last wins; r_last resets to 1 so requester 0 wins first.
  assign w_grant1 = req1 && (!req0 || !r_last);
  assign w_finish = (r_state == RUN) && (eng_finished || w_timeout);

`ifdef HASH_ARB_TIMEOUT_EN
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_count;
  logic       r_error;

  assign w_timeout = (r_state == RUN) && ((r_count + 8'd1) == LP_TIMEOUT);

  // Count is held at zero outside RUN, so it starts from zero on every RUN entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= 8'd0;
      r_error <= 1'b0;
    end else begin
      if (r_state == RUN) r_count <= r_count + 8'd1;
      else                r_count <= 8'd0;
      if (w_finish) r_error <= !eng_finished;
    end
  end

  assign error = r_error;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (req0 || req1) w_stateNext = CLEAR;
      CLEAR:   w_stateNext = RUN;
      RUN:     if (w_finish) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_busy       <= 1'b0;
      r_engEnable  <= 1'b0;
      r_engResetN  <= 1'b0;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_result     <= 8'h00;
      r_engMessage <= 8'h00;
    end else begin
      r_busy      <= (w_stateNext != IDLE);
      r_engEnable <= (w_stateNext == RUN);
      r_engResetN <= (w_stateNext != CLEAR);
      r_done0     <= (w_stateNext == DONE) && !r_owner;
      r_done1     <= (w_stateNext == DONE) && r_owner;
      if (r_state == IDLE && w_stateNext == CLEAR) begin
        r_owner      <= w_grant1;
        r_gnt0       <= !w_grant1;
        r_gnt1       <= w_grant1;
        r_engMessage <= w_grant1 ? msg1 : msg0;
      end
      if (r_state == DONE) begin
        r_gnt0 <= 1'b0;
        r_gnt1 <= 1'b0;
        r_last <= r_owner;
      end
      if (w_finish) r_result <= eng_finished ? eng_hash : 8'h00;
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign done0       = r_done0;
  assign done1       = r_done1;
  assign busy        = r_busy;
  assign result      = r_result;
  assign eng_message = r_engMessage;
  assign eng_enable  = r_engEnable;
  assign eng_reset_n = r_engResetN;

endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: directed bench for hash_arbiter with a cycle-level job model and a simple engine stand-in.
// Timeout scenarios run only when HASH_ARB_TIMEOUT_EN is defined.

module tb_hash_arbiter;

  localparam int TB_TIMEOUT = 8;
`ifdef HASH_ARB_TIMEOUT_EN
  localparam bit MODEL_TIMEOUT = 1'b1;
`else
  localparam bit MODEL_TIMEOUT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] msg0 = 8'h00;
  logic [7:0] msg1 = 8'h00;
  logic       gnt0, gnt1, done0, done1, error, busy, eng_enable, eng_reset_n;
  logic [7:0] result, eng_message;
  logic       eng_finished;
  logic [7:0] eng_hash;

  int checks = 0;
  int failures = 0;

  hash_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .msg0(msg0), .msg1(msg1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .result(result), .error(error),
    .busy(busy), .eng_message(eng_message), .eng_enable(eng_enable), .eng_reset_n(eng_reset_n),
    .eng_finished(eng_finished), .eng_hash(eng_hash)
  );

  always #5 clock = ~clock;

  // Engine stand-in: finishes once it has been enabled engLatency cycles since its last reset.
  int         engCount = 0;
  int         engLatency = 4;
  bit         engNever = 1'b0;
  bit         engSpurious = 1'b0;
  logic [7:0] engHashVal = 8'h00;

  always @(posedge clock) begin
    if (eng_reset_n === 1'b0) engCount <= 0;
    else if (eng_enable === 1'b1) engCount <= engCount + 1;
  end
  assign eng_finished = engSpurious || (!engNever && engCount >= engLatency);
  assign eng_hash     = engHashVal;

  // Job-level model: a job is granted, spends one clearing cycle, counts run cycles, then completes.
  bit         mValid = 1'b0;
  bit         mInReset, mActive, mOwner, mLast, mDone, mRunning, mError;
  int         mRunCycles;
  logic [7:0] mMsg, mResult;

  always @(posedge clock) begin
    if (reset) begin
      mValid = 1'b1; mInReset = 1'b1; mActive = 1'b0; mDone = 1'b0; mRunning = 1'b0;
      mLast = 1'b1; mOwner = 1'b0; mMsg = 8'h00; mResult = 8'h00; mError = 1'b0;
    end else begin
      mInReset = 1'b0;
      if (mActive && mDone) begin
        mLast = mOwner; mActive = 1'b0; mDone = 1'b0; mRunning = 1'b0;
      end else if (mActive && !mRunning) begin
        mRunning = 1'b1; mRunCycles = 0;
      end else if (mActive) begin
        mRunCycles++;
        if (eng_finished) begin
          mResult = eng_hash; mError = 1'b0; mDone = 1'b1;
        end else if (MODEL_TIMEOUT && mRunCycles == TB_TIMEOUT) begin
          mResult = 8'h00; mError = 1'b1; mDone = 1'b1;
        end
      end else if (req0 || req1) begin
        mOwner = (req0 && req1) ? !mLast : req1;
        mActive = 1'b1; mRunning = 1'b0;
        mMsg = mOwner ? msg1 : msg0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mValid) begin
      checkOutput("gnt0", 32'(gnt0), 32'(mActive && !mOwner));
      checkOutput("gnt1", 32'(gnt1), 32'(mActive && mOwner));
      checkOutput("done0", 32'(done0), 32'(mDone && !mOwner));
      checkOutput("done1", 32'(done1), 32'(mDone && mOwner));
      checkOutput("busy", 32'(busy), 32'(mActive));
      checkOutput("eng_enable", 32'(eng_enable), 32'(mActive && mRunning && !mDone));
      checkOutput("eng_reset_n", 32'(eng_reset_n), 32'(!(mInReset || (mActive && !mRunning))));
      checkOutput("eng_message", 32'(eng_message), 32'(mMsg));
      checkOutput("result", 32'(result), 32'(mResult));
      checkOutput("error", 32'(error), 32'(mError));
    end
  end

  int gnt0Cycles = 0, gnt1Cycles = 0, done0Pulses = 0, done1Pulses = 0, enCycles = 0;

  always @(negedge clock) begin
    if (gnt0 === 1'b1) gnt0Cycles++;
    if (gnt1 === 1'b1) gnt1Cycles++;
    if (done0 === 1'b1) done0Pulses++;
    if (done1 === 1'b1) done1Pulses++;
    if (eng_enable === 1'b1) enCycles++;
  end

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [7:0] m0, input logic [7:0] m1);
    req0 = r0; req1 = r1; msg0 = m0; msg1 = m1;
  endtask

  task automatic waitForDone(input int maxCycles, output int who);
    who = -1;
    for (int i = 0; i < maxCycles && who < 0; i++) begin
      @(negedge clock);
      if (done0 === 1'b1) who = 0;
      else if (done1 === 1'b1) who = 1;
    end
    if (who < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL doneWait actual=none required=pulse within %0d cycles", maxCycles);
    end
  endtask

  task automatic runJob(input logic r0, input logic r1, input logic [7:0] m0, input logic [7:0] m1,
                        output int who);
    applyStimulus(r0, r1, m0, m1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, m0, m1);
    waitForDone(300, who);
    stepCycles(1);
  endtask

  int who;
  int order[4];
  int base0, base1, baseD0, baseD1, baseEn;

  initial begin
    stepCycles(3);
    checkOutput("resetBusy", 32'(busy), 32'h0);
    checkOutput("resetEngResetN", 32'(eng_reset_n), 32'h0);
    checkOutput("resetResult", 32'(result), 32'h00);
    checkOutput("resetGnt0", 32'(gnt0), 32'h0);
    reset = 1'b0;
    stepCycles(2);
    checkOutput("postResetEngResetN", 32'(eng_reset_n), 32'h1);

    // Single request: 1 clear + 5 run + 1 done cycle of grant
    engLatency = 4; engHashVal = 8'hC3;
    base0 = gnt0Cycles; base1 = gnt1Cycles; baseD0 = done0Pulses;
    applyStimulus(1'b1, 1'b0, 8'h5A, 8'h00);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 8'h5A, 8'h00);
    stepCycles(12);
    checkOutput("singleGntCycles", 32'(gnt0Cycles - base0), 32'd7);
    checkOutput("singleDonePulses", 32'(done0Pulses - baseD0), 32'd1);
    checkOutput("singleGnt1Cycles", 32'(gnt1Cycles - base1), 32'd0);
    checkOutput("singleResult", 32'(result), 32'hC3);
    checkOutput("singleError", 32'(error), 32'h0);

    // Both held after reset: strict alternation starting with requester 0
    reset = 1'b1; stepCycles(2); reset = 1'b0; stepCycles(1);
    engLatency = 2; engHashVal = 8'h77;
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h20);
    for (int k = 0; k < 4; k++) begin
      waitForDone(50, who);
      order[k] = who;
    end
    applyStimulus(1'b0, 1'b0, 8'h10, 8'h20);
    stepCycles(2);
    checkOutput("order0", 32'(order[0]), 32'd0);
    checkOutput("order1", 32'(order[1]), 32'd1);
    checkOutput("order2", 32'(order[2]), 32'd0);
    checkOutput("order3", 32'(order[3]), 32'd1);

    // Message is latched at grant and ignores later msg1 changes
    engLatency = 6; engHashVal = 8'h3C;
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h11);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h11);
    stepCycles(2);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'hFF);
    checkOutput("msgHoldRun", 32'(eng_message), 32'h11);
    waitForDone(50, who);
    checkOutput("msgOwner", 32'(who), 32'd1);
    checkOutput("msgHoldDone", 32'(eng_message), 32'h11);
    stepCycles(1);
    checkOutput("msgHoldIdle", 32'(eng_message), 32'h11);

    // Reset during RUN discards the job
    engLatency = 10; engHashVal = 8'hEE;
    applyStimulus(1'b1, 1'b0, 8'h66, 8'hFF);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 8'h66, 8'hFF);
    stepCycles(3);
    baseD0 = done0Pulses;
    reset = 1'b1;
    stepCycles(1);
    checkOutput("midResetDone0", 32'(done0), 32'h0);
    checkOutput("midResetEngResetN", 32'(eng_reset_n), 32'h0);
    checkOutput("midResetGnt0", 32'(gnt0), 32'h0);
    checkOutput("midResetResult", 32'(result), 32'h00);
    checkOutput("midResetMessage", 32'(eng_message), 32'h00);
    reset = 1'b0;
    stepCycles(12);
    checkOutput("midResetNoDone", 32'(done0Pulses - baseD0), 32'd0);
    engLatency = 2; engHashVal = 8'h99;
    runJob(1'b1, 1'b0, 8'h01, 8'hFF, who);
    checkOutput("afterResetOwner", 32'(who), 32'd0);
    checkOutput("afterResetResult", 32'(result), 32'h99);

    // Request dropped during RUN still completes
    engLatency = 3; engHashVal = 8'h42;
    applyStimulus(1'b1, 1'b0, 8'hA1, 8'h00);
    stepCycles(3);
    applyStimulus(1'b0, 1'b0, 8'hA1, 8'h00);
    waitForDone(50, who);
    checkOutput("dropOwner", 32'(who), 32'd0);
    stepCycles(1);
    checkOutput("dropResult", 32'(result), 32'h42);

    // Stray engine completion while idle is ignored
    engSpurious = 1'b1;
    stepCycles(5);
    checkOutput("spuriousBusy", 32'(busy), 32'h0);
    engSpurious = 1'b0;
    stepCycles(1);

`ifdef HASH_ARB_TIMEOUT_EN
    engNever = 1'b1; engHashVal = 8'h5D;
    baseEn = enCycles;
    runJob(1'b1, 1'b0, 8'h05, 8'h00, who);
    checkOutput("timeoutRunCycles", 32'(enCycles - baseEn), 32'd8);
    checkOutput("timeoutError", 32'(error), 32'h1);
    checkOutput("timeoutResult", 32'(result), 32'h00);
    engNever = 1'b0; engLatency = 7; engHashVal = 8'hE7;
    runJob(1'b0, 1'b1, 8'h00, 8'h06, who);
    checkOutput("precedenceError", 32'(error), 32'h0);
    checkOutput("precedenceResult", 32'(result), 32'hE7);
`endif

    stepCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
